// File: rtl/uart_stream_pkg.sv
// Shared types and constants for the UART sample streamer.
// States, header byte values and the bytes-per-sample helper.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_C,
    HDR_H,
    CH_ID,
    DATA,
    NEXT
  } st_t;

  localparam logic [7:0] ASC_C = 8'h43;
  localparam logic [7:0] ASC_H = 8'h48;
  localparam logic [7:0] ASC_0 = 8'h30;

  function automatic int nb_of(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_sample_streamer_prio.sv
// Finds the lowest set mask bit at or above index `from`.
// In: mask, from. Out: nxt (index), found.
module prio_next_ch
  import uart_stream_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = 3
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CW-1:0]   from,
  output logic [CW-1:0]   nxt,
  output logic            found
);

  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (CW'(i) >= from)) begin
        nxt   = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_sample_streamer.sv
// Snapshots N_CH samples on a decimated sample_clk edge and streams them
// as "CH<id><bytes>" packets to uart_tx (tx_start/tx_data/tx_busy).
// Also: en, ch_mask, samples in; frame_active, drop_count, led_frame out.
module uart_sample_streamer
  import uart_stream_pkg::*;
#(
  parameter int W        = 16,
  parameter int N_CH     = 4,
  parameter int DECIMATE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_clk,
  input  logic            en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH*W-1:0] samples,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_busy,
  output logic            frame_active,
  output logic [7:0]      drop_count,
  output logic            led_frame
);

  localparam int NB = nb_of(W);
  localparam int EW = NB * 8;
  localparam int CW = $clog2(N_CH + 1);

  st_t state, state_n;
  logic [CW-1:0] ch, ch_n;
  logic [1:0] bidx, bidx_n;
  logic guard;
  logic sc_q;
  logic [15:0] dec_cnt;
  logic [N_CH*W-1:0] sh;
  logic [N_CH-1:0] shm;

  logic edge_s, trig, can_tx, load, done;
  logic [N_CH-1:0] pm;
  logic [CW-1:0] pfrom, pnxt;
  logic pfound;
  logic signed [W-1:0] cur;
  logic signed [EW-1:0] ext;

  assign edge_s = sample_clk & ~sc_q;
  assign trig = edge_s & en &
                (dec_cnt == 16'(DECIMATE - 1));
  assign can_tx = ~tx_busy & ~guard;
  assign frame_active = (state != IDLE);

  // IDLE picks the first channel from the live mask;
  // NEXT continues above ch in the shadow mask.
  assign pm = (state == IDLE) ? ch_mask : shm;
  assign pfrom = (state == IDLE) ? '0 : ch + CW'(1);

  prio_next_ch #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_prio (
    .mask  (pm),
    .from  (pfrom),
    .nxt   (pnxt),
    .found (pfound)
  );

  assign cur = sh[ch*W +: W];
  assign ext = EW'(cur);

  always_comb begin
    state_n  = state;
    ch_n     = ch;
    bidx_n   = bidx;
    tx_start = 1'b0;
    tx_data  = '0;
    load     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) begin
          load = 1'b1;
          if (pfound) begin
            ch_n    = pnxt;
            state_n = HDR_C;
          end
        end
      end
      HDR_C: begin
        if (can_tx) begin
          tx_start = 1'b1;
          tx_data  = ASC_C;
          state_n  = HDR_H;
        end
      end
      HDR_H: begin
        if (can_tx) begin
          tx_start = 1'b1;
          tx_data  = ASC_H;
          state_n  = CH_ID;
        end
      end
      CH_ID: begin
        if (can_tx) begin
          tx_start = 1'b1;
          tx_data  = ASC_0 + 8'(ch);
          bidx_n   = 2'(NB - 1);
          state_n  = DATA;
        end
      end
      DATA: begin
        if (can_tx) begin
          tx_start = 1'b1;
          tx_data  = ext[{bidx, 3'b000} +: 8];
          if (bidx == 2'd0) state_n = NEXT;
          else bidx_n = bidx - 2'd1;
        end
      end
      NEXT: begin
        if (pfound) begin
          ch_n    = pnxt;
          state_n = HDR_C;
        end else begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= '0;
      bidx       <= '0;
      guard      <= 1'b0;
      sc_q       <= 1'b0;
      dec_cnt    <= '0;
      sh         <= '0;
      shm        <= '0;
      drop_count <= '0;
      led_frame  <= 1'b0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      bidx  <= bidx_n;
      // Covers the cycle before uart_tx raises busy.
      guard <= tx_start;
      sc_q  <= sample_clk;
      if (!en) begin
        dec_cnt <= '0;
      end else if (edge_s) begin
        if (dec_cnt == 16'(DECIMATE - 1)) dec_cnt <= '0;
        else dec_cnt <= dec_cnt + 16'd1;
      end
      if (load) begin
        sh  <= samples;
        shm <= ch_mask;
      end
      if (trig && state != IDLE && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (done) led_frame <= ~led_frame;
    end
  end

endmodule
